// File: rtl/palette_lut_if.sv
// Bus bundle for palette_lut: pixel index path, shadow write port, flash
// controls and the registered VGA channel outputs.
//
// Handshake: wr_en is a valid-only strobe with no ready. Every cycle with
// wr_en=1 is one accepted write of wr_rgb into shadow entry wr_idx; the port
// never stalls. frame_start is a single-cycle event pulse. All other inputs
// are level signals that are sampled every clock.
interface palette_lut_if #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4
);
    logic [IDX_W-1:0]  color_idx;
    logic              blank;
    logic              frame_start;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CH_W-1:0] wr_rgb;
    logic              flash_en;
    logic [IDX_W-1:0]  flash_idx;
    logic [3*CH_W-1:0] flash_rgb;
    logic              commit_pending;
    logic [CH_W-1:0]   VGA_R;
    logic [CH_W-1:0]   VGA_G;
    logic [CH_W-1:0]   VGA_B;
    // Current flash phase, exposed for observation only.
    logic              dbg_phase;

    // Upstream side: index muxes, game logic and frame timing.
    modport master (
        output color_idx, blank, frame_start,
        output wr_en, wr_idx, wr_rgb,
        output flash_en, flash_idx, flash_rgb,
        input  commit_pending, VGA_R, VGA_G, VGA_B, dbg_phase
    );

    // The palette itself.
    modport slave (
        input  color_idx, blank, frame_start,
        input  wr_en, wr_idx, wr_rgb,
        input  flash_en, flash_idx, flash_rgb,
        output commit_pending, VGA_R, VGA_G, VGA_B, dbg_phase
    );
endinterface

// File: rtl/palette_lut.sv
// Double-buffered colour palette with frame-timed flash of one index.
// Writes land in a shadow table; the whole shadow is copied to the live
// table on the first frame_start after a write, so the picture never tears.
// The pixel path is a single registered stage: index -> live lookup -> VGA.
module palette_lut #(
    parameter int IDX_W     = 4,
    parameter int CH_W      = 4,
    parameter int FLASH_DIV = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    palette_lut_if.slave  bus
);
    localparam int PAL_N  = 1 << IDX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int FCNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLASH_DIV - 1);

    typedef logic [RGB_W-1:0] rgb_t;

    // Nibble-defined default colours, MSB-aligned into CH_W bits: wider
    // channels zero-fill the low bits, narrower ones keep the top bits.
    function automatic logic [CH_W-1:0] chan(input logic [3:0] nib);
        logic [31:0] ext;
        ext = {nib, 28'd0};
        return ext[31 -: CH_W];
    endfunction

    function automatic rgb_t rgb_def(input logic [3:0] r,
                                     input logic [3:0] g,
                                     input logic [3:0] b);
        return {chan(r), chan(g), chan(b)};
    endfunction

    function automatic rgb_t default_entry(input int i);
        rgb_t e;
        case (i)
            0, 3:    e = rgb_def(4'h0, 4'hF, 4'hB);
            1:       e = rgb_def(4'hF, 4'hE, 4'h0);
            2:       e = rgb_def(4'h6, 4'h1, 4'hE);
            default: e = '0;
        endcase
        return e;
    endfunction

    rgb_t              shadow_q [PAL_N];
    rgb_t              active_q [PAL_N];
    logic              commit_pending_q, commit_pending_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;
    rgb_t              rgb_q, rgb_d;
    logic              commit;

    // A commit needs both a frame boundary and something to publish.
    assign commit = bus.frame_start && commit_pending_q;

    // Shadow table: written directly by the write port, never stalls.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                shadow_q[i[IDX_W-1:0]] <= default_entry(i);
            end
        end else if (bus.wr_en) begin
            shadow_q[bus.wr_idx] <= bus.wr_rgb;
        end
    end

    // Live table: whole-array copy of the pre-write shadow on a commit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                active_q[i[IDX_W-1:0]] <= default_entry(i);
            end
        end else if (commit) begin
            active_q <= shadow_q;
        end
    end

    // Pending flag: a write always (re)arms it, even in a commit cycle,
    // so a write coinciding with frame_start goes live one frame later.
    always_comb begin
        commit_pending_d = commit_pending_q;
        if (bus.wr_en) begin
            commit_pending_d = 1'b1;
        end else if (commit) begin
            commit_pending_d = 1'b0;
        end
    end

    // Flash timing: count frames, toggle phase every FLASH_DIV frames;
    // disabling flash clears both so the next flash starts in phase 0.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (!bus.flash_en) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bus.frame_start) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    // Pixel select: blanking wins, then the flash override, then the table.
    always_comb begin
        rgb_d = active_q[bus.color_idx];
        if (!bus.blank) begin
            rgb_d = '0;
        end else if (bus.flash_en && phase_q &&
                     (bus.color_idx == bus.flash_idx)) begin
            rgb_d = bus.flash_rgb;
        end
    end

    // Control and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            commit_pending_q <= 1'b0;
            fcnt_q           <= '0;
            phase_q          <= 1'b0;
            rgb_q            <= '0;
        end else begin
            commit_pending_q <= commit_pending_d;
            fcnt_q           <= fcnt_d;
            phase_q          <= phase_d;
            rgb_q            <= rgb_d;
        end
    end

    assign bus.commit_pending = commit_pending_q;
    assign bus.dbg_phase      = phase_q;
    assign bus.VGA_R          = rgb_q[3*CH_W-1 -: CH_W];
    assign bus.VGA_G          = rgb_q[2*CH_W-1 -: CH_W];
    assign bus.VGA_B          = rgb_q[CH_W-1   -: CH_W];
endmodule

// File: doc/palette_lut.md
# palette_lut

Parametrised, writable colour palette for the VGA output path. It maps a per-pixel colour index to registered R/G/B channel values. The table is double-buffered: software/game logic writes a shadow copy, and that copy becomes live only at the next frame boundary, so the screen never tears. It also supports a frame-timed flash of one selectable index (blinking "press start" text, hit flashes). It sits between the sprite/background index muxes and the VGA DAC pins, and replaces the fixed per-screen combinational palettes.

## Interface
Parameters:
- IDX_W, 4, colour index width; palette depth is 2**IDX_W entries
- CH_W, 4, bits per colour channel
- FLASH_DIV, 8, frame_start pulses per flash phase toggle (≥1)

Ports:
- Clk  input  1  system/pixel clock
- Reset_n  input  1  asynchronous, active-low reset
- color_idx  input  IDX_W  pixel colour index, sampled every cycle
- blank  input  1  active-low blanking; 0 forces black output
- frame_start  input  1  one-cycle pulse at start of vertical blank
- wr_en  input  1  write strobe into shadow palette
- wr_idx  input  IDX_W  shadow entry to write
- wr_rgb  input  3*CH_W  {R,G,B} value written
- flash_en  input  1  enable flashing of flash_idx
- flash_idx  input  IDX_W  index that flashes
- flash_rgb  input  3*CH_W  {R,G,B} shown during flash phase 1
- commit_pending  output  1  shadow holds writes not yet live
- VGA_R, VGA_G, VGA_B  output  CH_W each  registered channel outputs

## Operation
- Two arrays: shadow[2**IDX_W] and active[2**IDX_W], each 3*CH_W bits wide.
- Reset defaults, identical in both arrays. Values are given for CH_W=4. For other widths each nibble is MSB-aligned and the low bits are zero-filled; for CH_W<4 the nibble is truncated to its top bits.
  - idx0 = {0,F,B}
  - idx1 = {F,E,0}
  - idx2 = {6,1,E}
  - idx3 = {0,F,B}
  - all other entries = {0,0,0}
- Write: when wr_en=1, shadow[wr_idx] <= wr_rgb and commit_pending <= 1. Multiple writes to the same index before a commit: last write wins.
- Commit: when frame_start=1 and commit_pending=1, active <= shadow (whole array) and commit_pending <= 0.
- Write in the same cycle as a committing frame_start:
  - The commit copies the pre-write shadow contents.
  - The write still lands in shadow.
  - commit_pending stays 1, so the write goes live at the following frame_start.
- Flash state:
  - Registers: frame counter fcnt (0..FLASH_DIV-1) and phase bit.
  - Each frame_start with flash_en=1: if fcnt==FLASH_DIV-1, fcnt <= 0 and phase toggles; otherwise fcnt increments.
  - flash_en=0: fcnt <= 0 and phase <= 0 (synchronous clear). Flashing always restarts in phase 0.
- Pixel path, evaluated each cycle and registered:
  - blank=0 → {0,0,0}
  - else if flash_en=1, phase=1 and color_idx==flash_idx → flash_rgb
  - else active[color_idx]
- flash_idx and flash_rgb are used live, with no shadowing.
- Reset mid-operation: active and shadow return to the defaults, and pending writes are discarded.

## Timing
- Async reset values:
  - VGA_R/G/B = 0
  - commit_pending = 0
  - fcnt = 0, phase = 0
  - arrays hold the defaults
- Pixel latency is exactly 1 cycle. VGA_* at edge N+1 reflect color_idx, blank, flash state and active as they were at edge N. Upstream aligns blank and sync to this 1-cycle delay.
- A commit at edge N affects pixels sampled from edge N+1 on, so output from N+2 shows the new colours.
- Phase toggle at edge N affects output from N+2.
- The write port never stalls: one write per cycle, no handshake.
- The flash period is 2*FLASH_DIV frames; each phase lasts FLASH_DIV frames.
- Arrays may be flops or distributed RAM. Active read is asynchronous within the cycle; no extra pipeline stage.

## Test plan
- Reset then pixel sweep: release Reset_n, blank=1, drive idx 0,1,2,3,5 on consecutive cycles → one cycle later outputs {0,F,B},{F,E,0},{6,1,E},{0,F,B},{0,0,0}. Before release, all outputs are 0.
- Blank: color_idx=1 with blank=0 → output {0,0,0} next cycle. Raising blank → {F,E,0} the cycle after.
- Deferred commit:
  - Write idx2={A,5,3}, commit_pending → 1.
  - idx2 still reads {6,1,E} until frame_start.
  - After the frame_start edge, pending → 0 and idx2 reads {A,5,3}.
- Write coinciding with frame_start:
  - Write idx4={1,2,3}, then write idx5={F,F,F} in the frame_start cycle.
  - After the first commit: idx4={1,2,3}, idx5 still {0,0,0}, pending=1.
  - The next frame_start makes idx5={F,F,F} and clears pending.
- Flash with FLASH_DIV=2, flash_en=1, flash_idx=1, flash_rgb={F,F,F}:
  - Frames 0-1 show {F,E,0}; frames 2-3 show {F,F,F}; frames 4-5 show {F,E,0}.
  - Other indices are unaffected.
  - Dropping flash_en mid-phase-1 restores {F,E,0} within 2 cycles.
- Reset mid-operation: issue pending writes and a flash in phase 1, then assert Reset_n=0 → outputs 0 immediately. After release, the default palette is back, pending=0 and phase=0.
